// File: rtl/spi_rom_master.sv
// SPI mode-0 master for the ASCII-ROM slave: sends an 8-bit start address MSB first,
// then clocks back a requested number of bytes and presents each one with a valid pulse.
module spi_rom_master #(
    parameter int HALF_DIV = 8,
    parameter int GAP_HALF = 4,
    parameter int LEN_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [7:0]       i_addr,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_abort,
    input  logic             i_miso,
    output logic             o_sck,
    output logic             o_mosi,
    output logic             o_en_n,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int               DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ADDR,
        S_GAP,
        S_DATA,
        S_HOLD,
        S_CS_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       half_q, half_d;
    logic [6:0]       addr_q, addr_d;
    logic [6:0]       rx_q, rx_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             miso_meta, miso_sync;

    logic             sck_d, mosi_d, en_n_d, valid_d, busy_d, done_d;
    logic [7:0]       data_d;

    logic             wrap;
    logic             abort_now;

    assign wrap      = (div_q == DIV_LAST);
    assign abort_now = abort_q | i_abort;

    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        addr_d  = addr_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        sck_d   = o_sck;
        mosi_d  = o_mosi;
        en_n_d  = o_en_n;
        data_d  = o_data;
        valid_d = 1'b0;
        busy_d  = o_busy;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            div_d = wrap ? '0 : div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                div_d   = '0;
                abort_d = 1'b0;
                if (i_start) begin
                    addr_d  = i_addr[6:0];
                    cnt_d   = i_len;
                    busy_d  = 1'b1;
                    en_n_d  = 1'b0;
                    mosi_d  = i_addr[7];
                    sck_d   = 1'b0;
                    half_d  = '0;
                    state_d = S_SETUP;
                end
            end

            S_SETUP, S_ADDR, S_GAP, S_DATA: begin
                if (i_abort) abort_d = 1'b1;
                if (wrap && abort_now) begin
                    // A partially shifted byte is simply dropped; the 8th-bit sample never happens.
                    sck_d   = 1'b0;
                    mosi_d  = 1'b0;
                    abort_d = 1'b0;
                    half_d  = '0;
                    state_d = S_HOLD;
                end else if (wrap) begin
                    case (state_q)
                        S_SETUP: begin
                            sck_d   = 1'b1;
                            half_d  = '0;
                            state_d = S_ADDR;
                        end
                        S_ADDR: begin
                            if (!half_q[0]) begin
                                sck_d = 1'b0;
                                if (half_q == 8'd14) begin
                                    mosi_d  = 1'b0;
                                    half_d  = '0;
                                    state_d = (cnt_q == '0) ? S_HOLD : S_GAP;
                                end else begin
                                    mosi_d = addr_q[6];
                                    addr_d = {addr_q[5:0], 1'b0};
                                    half_d = half_q + 8'd1;
                                end
                            end else begin
                                sck_d  = 1'b1;
                                half_d = half_q + 8'd1;
                            end
                        end
                        S_GAP: begin
                            if (half_q == GAP_LAST) begin
                                half_d  = '0;
                                state_d = S_DATA;
                            end else begin
                                half_d = half_q + 8'd1;
                            end
                        end
                        S_DATA: begin
                            // Even halves are low: sample at their last cycle, then raise SCK.
                            if (!half_q[0]) begin
                                rx_d   = {rx_q[5:0], miso_sync};
                                sck_d  = 1'b1;
                                half_d = half_q + 8'd1;
                                if (half_q == 8'd14) begin
                                    data_d  = {rx_q, miso_sync};
                                    valid_d = 1'b1;
                                    cnt_d   = cnt_q - 1'b1;
                                end
                            end else begin
                                sck_d = 1'b0;
                                if (half_q == 8'd15) begin
                                    half_d = '0;
                                    if (cnt_q == '0) state_d = S_HOLD;
                                end else begin
                                    half_d = half_q + 8'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_HOLD: begin
                if (wrap) begin
                    en_n_d  = 1'b1;
                    state_d = S_CS_HIGH;
                end
            end

            S_CS_HIGH: begin
                if (wrap) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            half_q    <= '0;
            addr_q    <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
            o_sck     <= 1'b0;
            o_mosi    <= 1'b0;
            o_en_n    <= 1'b1;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            addr_q    <= addr_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            miso_meta <= i_miso;
            miso_sync <= miso_meta;
            o_sck     <= sck_d;
            o_mosi    <= mosi_d;
            o_en_n    <= en_n_d;
            o_data    <= data_d;
            o_valid   <= valid_d;
            o_busy    <= busy_d;
            o_done    <= done_d;
        end
    end

endmodule
